regfile_dump_unit: RTL and testbench

Debug reader for the processor's register file. When a programmed cycle count is reached, it freezes the pipeline with a halt request. It then reads registers 0..NUM_REGS-1 through a spare synchronous read port and streams each value with its index on a valid/ready interface. This gives the bench or a host a protocol-level end-of-run state capture in place of hierarchical peeking. It sits beside the register file in Top and takes the same clk.

---
 rtl/regfile_dump_unit.sv | 118 +++++++++++
 tb/tb_regfile_dump_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_unit.sv
// Debug reader: at a programmed cycle it halts the pipeline and streams every register as (idx, data) beats.
// Latency: first dump_valid 2 cycles after the cycle where cycle_count==trigger; 2 cycles per beat minimum.
// Backpressure: OUT holds idx/data/last stable while dump_valid && !dump_ready, for as long as needed.
module regfile_dump_unit #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3,
    parameter int DATA_W   = 32,
    parameter int CYCLE_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic [CYCLE_W-1:0] trigger_cycle,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               halt_req,
    output logic               rf_rd_en,
    output logic [IDX_W-1:0]   rf_rd_addr,
    input  logic [DATA_W-1:0]  rf_rd_data,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [IDX_W-1:0]   dump_idx,
    output logic [DATA_W-1:0]  dump_data,
    output logic               dump_last,
    output logic               busy,
    output logic               done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_READ,
        S_OUT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CYCLE_W-1:0]  cycle_q, cycle_d;
    logic [CYCLE_W-1:0]  trig_q, trig_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    // High during the first OUT cycle, when rf_rd_data is still live and data_q not yet loaded.
    logic                first_q, first_d;

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q + CYCLE_W'(1);
        trig_d  = trig_q;
        idx_d   = idx_q;
        data_d  = data_q;
        first_d = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    trig_d  = trigger_cycle;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (cycle_q == trig_q) begin
                    idx_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                first_d = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (first_q) begin
                    data_d = rf_rd_data;
                end
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cycle_q <= '0;
            trig_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            trig_q  <= trig_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            first_q <= first_d;
        end
    end

    // Every output is decoded from flops or the read-port data; dump_ready only steers next state.
    assign cycle_count = cycle_q;
    assign halt_req    = (state_q == S_READ) || (state_q == S_OUT);
    assign rf_rd_en    = (state_q == S_READ);
    assign rf_rd_addr  = rf_rd_en ? idx_q : '0;
    assign dump_valid  = (state_q == S_OUT);
    assign dump_idx    = dump_valid ? idx_q : '0;
    assign dump_last   = dump_valid && (idx_q == LAST_IDX);
    assign dump_data   = dump_valid ? (first_q ? rf_rd_data : data_q) : '0;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Bench for regfile_dump_unit with a 6-bit cycle counter so counter wrap is reachable.
// Expected beats are queued at arm time and popped as the DUT hands them over.
module tb_regfile_dump_unit;

    typedef struct packed {
        logic [2:0]  idx;
        logic [31:0] dat;
        logic        last;
    } beat_t;

    logic        clk;
    logic        reset;
    logic        arm;
    logic [5:0]  trigger_cycle;
    logic [5:0]  cycle_count;
    logic        halt_req;
    logic        rf_rd_en;
    logic [2:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [2:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        busy;
    logic        done;

    regfile_dump_unit #(
        .NUM_REGS(8),
        .IDX_W   (3),
        .DATA_W  (32),
        .CYCLE_W (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .trigger_cycle(trigger_cycle),
        .cycle_count  (cycle_count),
        .halt_req     (halt_req),
        .rf_rd_en     (rf_rd_en),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_data   (rf_rd_data),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_idx     (dump_idx),
        .dump_data    (dump_data),
        .dump_last    (dump_last),
        .busy         (busy),
        .done         (done)
    );

    logic [31:0] mem [8];
    beat_t       exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          accepts = 0;
    logic        stall_mode = 1'b0;
    int          scnt = 0;
    logic        hold_pend = 1'b0;
    logic [2:0]  held_idx;
    logic [31:0] held_dat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read port: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rf_rd_en) rf_rd_data <= mem[rf_rd_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumer: always ready, or ready only after a beat has waited 5 cycles.
    initial begin
        dump_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_mode) begin
                dump_ready = 1'b1;
            end else if (dump_valid && scnt >= 5) begin
                dump_ready = 1'b1;
            end else if (dump_valid) begin
                dump_ready = 1'b0;
                scnt++;
            end else begin
                dump_ready = 1'b0;
                scnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_vld", dump_valid, 1'b1);
                check("hold_idx", dump_idx, held_idx);
                check("hold_dat", dump_data, held_dat);
            end
            if (dump_valid && dump_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", dump_valid, 1'b0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat_idx", dump_idx, b.idx);
                    check("beat_dat", dump_data, b.dat);
                    check("beat_last", dump_last, b.last);
                    accepts++;
                end
            end
            hold_pend = dump_valid && !dump_ready;
            held_idx  = dump_idx;
            held_dat  = dump_data;
        end
    end

    task automatic start_dump(input logic [5:0] t);
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.idx  = 3'(i);
            b.dat  = mem[i];
            b.last = (i == 7);
            exp_q.push_back(b);
        end
        accepts = 0;
        arm = 1'b1;
        trigger_cycle = t;
        tick();
        arm = 1'b0;
        check("arm_busy", busy, 1'b1);
        check("arm_done_clr", done, 1'b0);
    endtask

    task automatic finish_dump(input logic [5:0] t, input logic stall, input logic mid_arm);
        int   n;
        int   nvld;
        logic sent;
        logic [5:0] want;
        sent = 1'b0;
        for (int i = 0; i < 200 && !halt_req; i++) tick();
        check("halt_seen", halt_req, 1'b1);
        // Halt rises on the edge that closes the cycle where cycle_count == trigger.
        want = t + 6'd1;
        check("halt_cnt", cycle_count, want);
        tick();
        want = t + 6'd2;
        check("first_vld", dump_valid, 1'b1);
        check("first_cnt", cycle_count, want);
        check("first_idx", dump_idx, 3'd0);
        n = 1;
        nvld = 1;
        while (!done && n < 600) begin
            arm = 1'b0;
            if (mid_arm && !sent && dump_valid && dump_idx == 3'd2) begin
                arm = 1'b1;
                trigger_cycle = 6'(99);
                sent = 1'b1;
            end
            tick();
            n++;
            if (dump_valid) nvld++;
        end
        arm = 1'b0;
        check("done_seen", done, 1'b1);
        check("done_halt", halt_req, 1'b0);
        check("done_vld", dump_valid, 1'b0);
        check("done_busy", busy, 1'b0);
        check("accepts", accepts, 8);
        check("queue_empty", exp_q.size(), 0);
        if (!stall) begin
            check("trig_to_done", n, 16);
            check("vld_cycles", nvld, 8);
        end
    endtask

    initial begin
        logic [5:0] t;
        reset = 1'b1;
        arm = 1'b0;
        trigger_cycle = '0;
        mem[0] = 32'd5;  mem[1] = 32'd0;  mem[2] = 32'd0;  mem[3] = 32'd15;
        mem[4] = 32'd20; mem[5] = 32'd24; mem[6] = 32'd28; mem[7] = 32'd7;
        tick();
        tick();
        check("rst_cnt", cycle_count, 6'd0);
        check("rst_halt", halt_req, 1'b0);
        check("rst_vld", dump_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rden", rf_rd_en, 1'b0);
        reset = 1'b0;

        // Basic dump, consumer always ready.
        start_dump(6'd25);
        finish_dump(6'd25, 1'b0, 1'b0);

        // Slow consumer, re-armed from DONE.
        stall_mode = 1'b1;
        t = cycle_count + 6'd6;
        start_dump(t);
        finish_dump(t, 1'b1, 1'b0);
        stall_mode = 1'b0;

        // Arm mid-dump is ignored, then a re-arm from DONE works with new data.
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        t = cycle_count + 6'd6;
        start_dump(t);
        finish_dump(t, 1'b0, 1'b1);
        t = cycle_count + 6'd6;
        start_dump(t);
        finish_dump(t, 1'b0, 1'b0);

        // Reset while beat 3 is on the bus.
        t = cycle_count + 6'd6;
        start_dump(t);
        for (int i = 0; i < 200 && !(dump_valid && dump_idx == 3'd3); i++) tick();
        check("pre_rst_idx3", dump_idx, 3'd3);
        reset = 1'b1;
        tick();
        check("mid_rst_cnt", cycle_count, 6'd0);
        check("mid_rst_halt", halt_req, 1'b0);
        check("mid_rst_vld", dump_valid, 1'b0);
        check("mid_rst_idx", dump_idx, 3'd0);
        check("mid_rst_dat", dump_data, 32'd0);
        check("mid_rst_last", dump_last, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_rden", rf_rd_en, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        start_dump(6'd10);
        finish_dump(6'd10, 1'b0, 1'b0);

        // Trigger already passed: must wait for the counter to wrap.
        for (int i = 0; i < 100 && cycle_count != 6'd20; i++) tick();
        check("at_cnt20", cycle_count, 6'd20);
        start_dump(6'd4);
        finish_dump(6'd4, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
